// File: rtl/player_bullet_pool_if.sv
// Signal bundle between the game logic / enemy blocks and the player bullet pool.
// Slot outputs bX*/bY* feed the enemy collision inputs; hit_mask comes back from them.
interface player_bullet_pool_if;
  logic       play;
  logic [7:0] keycode;
  logic       scroll;
  logic [9:0] playerX;
  logic [9:0] playerY;
  logic       facing;
  logic [4:0] hit_mask;
  logic [9:0] bX0, bX1, bX2, bX3, bX4;
  logic [9:0] bY0, bY1, bY2, bY3, bY4;
  logic [4:0] active;

  modport master (
    output play, keycode, scroll, playerX, playerY, facing, hit_mask,
    input  bX0, bX1, bX2, bX3, bX4, bY0, bY1, bY2, bY3, bY4, active
  );

  modport slave (
    input  play, keycode, scroll, playerX, playerY, facing, hit_mask,
    output bX0, bX1, bX2, bX3, bX4, bY0, bY1, bY2, bY3, bY4, active
  );
endinterface

// File: rtl/player_bullet_pool.sv
// Five-slot player projectile pool: spawns on a fire-key edge, moves once per frame,
// retires on enemy hit or on leaving the 0..639 horizontal range. Inactive slots park at (0,0).
module player_bullet_pool #(
  parameter logic [7:0] FIRE_KEY  = 8'h0D,
  parameter logic [9:0] SPEED     = 10'd6,
  parameter logic [9:0] SCROLL_DX = 10'd2,
  parameter logic [9:0] SPAWN_DX  = 10'd24,
  parameter logic [9:0] SPAWN_DY  = 10'd20,
  parameter logic [7:0] COOLDOWN  = 8'd8
) (
  input logic                  frame_clk,
  input logic                  Reset,
  player_bullet_pool_if.slave  bus
);

  logic [4:0]       active_q, active_d;
  logic [4:0]       dir_q, dir_d;
  logic [4:0][9:0]  x_q, x_d;
  logic [4:0][9:0]  y_q, y_d;
  logic [7:0]       cool_q, cool_d;
  logic [7:0]       prev_key_q, prev_key_d;

  logic             fire_s;
  logic             slot_ok_s;
  logic [2:0]       slot_s;
  logic             left_bad_s;
  logic             accept_s;
  logic [9:0]       spawn_x_s;
  logic [9:0]       spawn_y_s;
  logic [4:0][10:0] up_s, dec_s, nx_s;
  logic [4:0]       retire_s;

  // State registers, cleared asynchronously on Reset.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      active_q   <= 5'd0;
      dir_q      <= 5'd0;
      x_q        <= '0;
      y_q        <= '0;
      cool_q     <= 8'd0;
      prev_key_q <= 8'd0;
    end else begin
      active_q   <= active_d;
      dir_q      <= dir_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cool_q     <= cool_d;
      prev_key_q <= prev_key_d;
    end
  end

  // Lowest-index free slot, judged on pre-edge state so a slot retired this frame is not reused.
  always_comb begin
    slot_ok_s = 1'b1;
    slot_s    = 3'd0;
    casez (active_q)
      5'b????0: slot_s = 3'd0;
      5'b???01: slot_s = 3'd1;
      5'b??011: slot_s = 3'd2;
      5'b?0111: slot_s = 3'd3;
      5'b01111: slot_s = 3'd4;
      default:  slot_ok_s = 1'b0;
    endcase
  end

  // Fire request and spawn coordinates; a left-facing spawn that would go negative is dropped.
  always_comb begin
    fire_s     = bus.play && (bus.keycode == FIRE_KEY) && (prev_key_q != FIRE_KEY) && (cool_q == 8'd0);
    left_bad_s = !bus.facing && (bus.playerX < SPAWN_DX);
    accept_s   = fire_s && slot_ok_s && !left_bad_s;
    spawn_x_s  = bus.facing ? (bus.playerX + SPAWN_DX) : (bus.playerX - SPAWN_DX);
    spawn_y_s  = (bus.playerY < SPAWN_DY) ? 10'd0 : (bus.playerY - SPAWN_DY);
  end

  // 11-bit move with borrow check; retire on hit, underflow or passing the right edge.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      up_s[i]     = {1'b0, x_q[i]} + (dir_q[i] ? {1'b0, SPEED} : 11'd0);
      dec_s[i]    = (dir_q[i] ? 11'd0 : {1'b0, SPEED}) + (bus.scroll ? {1'b0, SCROLL_DX} : 11'd0);
      nx_s[i]     = up_s[i] - dec_s[i];
      retire_s[i] = bus.hit_mask[i] || (up_s[i] < dec_s[i]) || (nx_s[i] > 11'd639);
    end
  end

  // Next-state: spawn wins over hit/move on the allocated slot; play=0 freezes everything.
  always_comb begin
    active_d   = active_q;
    dir_d      = dir_q;
    x_d        = x_q;
    y_d        = y_q;
    cool_d     = cool_q;
    prev_key_d = prev_key_q;
    if (bus.play) begin
      prev_key_d = bus.keycode;
      for (int i = 0; i < 5; i++) begin
        if (accept_s && (slot_s == 3'(i))) begin
          active_d[i] = 1'b1;
          dir_d[i]    = bus.facing;
          x_d[i]      = spawn_x_s;
          y_d[i]      = spawn_y_s;
        end else if (active_q[i] && retire_s[i]) begin
          active_d[i] = 1'b0;
          x_d[i]      = 10'd0;
          y_d[i]      = 10'd0;
        end else if (active_q[i]) begin
          x_d[i] = nx_s[i][9:0];
        end else begin
          x_d[i] = x_q[i];
        end
      end
      if (accept_s) begin
        cool_d = COOLDOWN;
      end else if (cool_q != 8'd0) begin
        cool_d = cool_q - 8'd1;
      end else begin
        cool_d = cool_q;
      end
    end else begin
      cool_d = cool_q;
    end
  end

  assign bus.active = active_q;
  assign bus.bX0 = x_q[0];
  assign bus.bX1 = x_q[1];
  assign bus.bX2 = x_q[2];
  assign bus.bX3 = x_q[3];
  assign bus.bX4 = x_q[4];
  assign bus.bY0 = y_q[0];
  assign bus.bY1 = y_q[1];
  assign bus.bY2 = y_q[2];
  assign bus.bY3 = y_q[3];
  assign bus.bY4 = y_q[4];

endmodule
